// File: rtl/cgra_pwr_seq_pkg.sv
// Shared definitions for the CGRA external-domain power sequencer.
// Holds the state encodings, default timing constants and the pin-level
// output bundle. The register file and the C header generator reuse these.
package cgra_pwr_seq_pkg;

  typedef logic [3:0] pwr_state_t;

  localparam pwr_state_t ST_ON      = 4'd0;
  localparam pwr_state_t ST_DRAIN   = 4'd1;
  localparam pwr_state_t ST_ISO     = 4'd2;
  localparam pwr_state_t ST_RST     = 4'd3;
  localparam pwr_state_t ST_OFF_REQ = 4'd4;
  localparam pwr_state_t ST_OFF     = 4'd5;
  localparam pwr_state_t ST_ON_REQ  = 4'd6;
  localparam pwr_state_t ST_SETTLE  = 4'd7;
  localparam pwr_state_t ST_UNISO   = 4'd8;
  localparam pwr_state_t ST_ERR     = 4'd9;

  localparam int unsigned DEF_ISO_DLY     = 4;
  localparam int unsigned DEF_RST_DLY     = 4;
  localparam int unsigned DEF_ACK_TIMEOUT = 255;
  localparam int unsigned DEF_CNT_W       = 8;

  // Power-pin bundle driven towards the external domain.
  typedef struct packed {
    logic sw;     // 1 = command domain off
    logic iso;    // 1 = outputs isolated
    logic rst_n;  // domain reset, active-low
    logic ret;    // memory retention enable
  } pwr_out_t;

  localparam pwr_out_t OUT_ON = '{sw: 1'b0, iso: 1'b0, rst_n: 1'b1, ret: 1'b0};

  // States in which the shared counter runs (hold or acknowledge timeout).
  function automatic logic is_timed_state(pwr_state_t s);
    return (s == ST_ISO)     || (s == ST_RST)    || (s == ST_OFF_REQ) ||
           (s == ST_ON_REQ)  || (s == ST_SETTLE) || (s == ST_UNISO);
  endfunction

endpackage

// File: rtl/cgra_pwr_ack_sync.sv
// Two-flop synchronizer for the asynchronous power-switch acknowledge.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous reset, active-high (both flops clear to 0)
//   async_i - raw switch acknowledge from the external domain
//   sync_o  - acknowledge in the clk_i domain, two cycles of latency
module cgra_pwr_ack_sync
  import cgra_pwr_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/cgra_pwr_seq.sv
// Power-domain sequencer for the CGRA external subsystem. Drains, isolates,
// resets and switches off the CGRA on a sleep request; powers it back up in
// reverse order on a wake request; faults to a safe-off error state when the
// switch acknowledge does not arrive in time.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   sleep_req_i, wake_req_i   - single-cycle power-down / power-up requests
//   ret_mode_i                - retention mode, sampled when sleep is accepted
//   cgra_busy_i               - CGRA still has work or bus traffic in flight
//   pwr_ack_i                 - asynchronous switch status, 1 = domain off
//   err_clr_i                 - leaves the error state
//   pwr_switch_o, iso_o, dom_rst_no, ret_o - registered power pins
//   state_o, busy_o, done_o, err_o         - registered status
//
// state    | meaning
// ---------+----------------------------------------------------------
// ON       | domain powered, running
// DRAIN    | waiting for the CGRA to go idle
// ISO      | outputs isolated, retention applied, ISO_DLY hold
// RST      | domain reset asserted, RST_DLY hold
// OFF_REQ  | switch commanded off, waiting for ack (timeout -> ERR)
// OFF      | domain off
// ON_REQ   | switch commanded on, waiting for ack release (timeout -> ERR)
// SETTLE   | power settling under reset, RST_DLY hold
// UNISO    | isolation released, reset still held, ISO_DLY hold
// ERR      | switch fault, domain forced safe-off until err_clr_i
module cgra_pwr_seq
  import cgra_pwr_seq_pkg::*;
#(
  parameter int unsigned ISO_DLY     = DEF_ISO_DLY,
  parameter int unsigned RST_DLY     = DEF_RST_DLY,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sleep_req_i,
  input  logic       wake_req_i,
  input  logic       ret_mode_i,
  input  logic       cgra_busy_i,
  input  logic       pwr_ack_i,
  input  logic       err_clr_i,
  output logic       pwr_switch_o,
  output logic       iso_o,
  output logic       dom_rst_no,
  output logic       ret_o,
  output logic [3:0] state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  logic             ack_s;
  pwr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ret_lat_q, ret_lat_d;
  pwr_out_t         out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             iso_tc, rst_tc, ack_tc;

  cgra_pwr_ack_sync u_ack_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (pwr_ack_i),
    .sync_o  (ack_s)
  );

  // Terminal counts: counter starts at 0 on entry, so N-1 gives an N-cycle hold.
  assign iso_tc = (cnt_q == CNT_W'(ISO_DLY - 1));
  assign rst_tc = (cnt_q == CNT_W'(RST_DLY - 1));
  assign ack_tc = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ret_lat_d = ret_lat_q;
    case (state_q)
      ST_ON: begin
        if (sleep_req_i && !wake_req_i) begin
          state_d   = ST_DRAIN;
          ret_lat_d = ret_mode_i;
        end
      end
      ST_DRAIN:   if (!cgra_busy_i) state_d = ST_ISO;
      ST_ISO:     if (iso_tc)       state_d = ST_RST;
      ST_RST:     if (rst_tc)       state_d = ST_OFF_REQ;
      ST_OFF_REQ: begin
        // An ack arriving on the last allowed cycle still counts.
        if (ack_s)       state_d = ST_OFF;
        else if (ack_tc) state_d = ST_ERR;
      end
      ST_OFF:     if (wake_req_i && !sleep_req_i) state_d = ST_ON_REQ;
      ST_ON_REQ: begin
        if (!ack_s)      state_d = ST_SETTLE;
        else if (ack_tc) state_d = ST_ERR;
      end
      ST_SETTLE:  if (rst_tc)    state_d = ST_UNISO;
      ST_UNISO:   if (iso_tc)    state_d = ST_ON;
      ST_ERR:     if (err_clr_i) state_d = ST_OFF;
      // Unused encodings can only come from an upset; park the domain safe-off.
      default:    state_d = ST_ERR;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || !is_timed_state(state_q)) cnt_d = '0;
    else                                                  cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with state_o on the same cycle.
  always_comb begin
    out_d = OUT_ON;
    case (state_d)
      ST_ISO: begin
        out_d.iso = 1'b1;
        out_d.ret = ret_lat_d;
      end
      ST_RST, ST_ON_REQ, ST_SETTLE: begin
        out_d.iso   = 1'b1;
        out_d.rst_n = 1'b0;
        out_d.ret   = ret_lat_d;
      end
      ST_OFF_REQ, ST_OFF, ST_ERR: begin
        out_d.sw    = 1'b1;
        out_d.iso   = 1'b1;
        out_d.rst_n = 1'b0;
        out_d.ret   = ret_lat_d;
      end
      ST_UNISO: begin
        out_d.rst_n = 1'b0;
      end
      default: out_d = OUT_ON;
    endcase
    busy_d = !((state_d == ST_ON) || (state_d == ST_OFF) || (state_d == ST_ERR));
    // ERR -> OFF is a recovery, not a completed transition, so it is excluded.
    done_d = ((state_q == ST_OFF_REQ) && (state_d == ST_OFF)) ||
             ((state_q == ST_UNISO)   && (state_d == ST_ON));
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ON;
      cnt_q     <= '0;
      ret_lat_q <= 1'b0;
      out_q     <= OUT_ON;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ret_lat_q <= ret_lat_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pwr_switch_o = out_q.sw;
  assign iso_o        = out_q.iso;
  assign dom_rst_no   = out_q.rst_n;
  assign ret_o        = out_q.ret;
  assign state_o      = state_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cgra_pwr_seq.sv
module tb_cgra_pwr_seq;

  localparam int ISO_DLY     = 4;
  localparam int RST_DLY     = 4;
  localparam int ACK_TIMEOUT = 255;

  localparam logic [3:0] M_ON = 4'd0, M_DRAIN = 4'd1, M_ISO = 4'd2, M_RST = 4'd3,
                         M_OFF_REQ = 4'd4, M_OFF = 4'd5, M_ON_REQ = 4'd6,
                         M_SETTLE = 4'd7, M_UNISO = 4'd8, M_ERR = 4'd9;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sleep_req_i = 1'b0;
  logic       wake_req_i = 1'b0;
  logic       ret_mode_i = 1'b0;
  logic       cgra_busy_i = 1'b0;
  logic       pwr_ack_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       pwr_switch_o, iso_o, dom_rst_no, ret_o, busy_o, done_o, err_o;
  logic [3:0] state_o;

  cgra_pwr_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sleep_req_i  (sleep_req_i),
    .wake_req_i   (wake_req_i),
    .ret_mode_i   (ret_mode_i),
    .cgra_busy_i  (cgra_busy_i),
    .pwr_ack_i    (pwr_ack_i),
    .err_clr_i    (err_clr_i),
    .pwr_switch_o (pwr_switch_o),
    .iso_o        (iso_o),
    .dom_rst_no   (dom_rst_no),
    .ret_o        (ret_o),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Switch model: ack follows the switch command, optionally slow or stuck.
  bit ack_stuck0 = 1'b0;
  bit ack_stuck1 = 1'b0;
  bit ack_slow   = 1'b0;
  always @(negedge clk_i) begin
    if (ack_stuck0)      pwr_ack_i = 1'b0;
    else if (ack_stuck1) pwr_ack_i = 1'b1;
    else if (!(ack_slow && ($urandom_range(0, 2) == 0))) pwr_ack_i = pwr_switch_o;
  end

  // Behavioural reference: phase plus cycles remaining in the phase.
  typedef struct packed {
    logic [3:0]  ph;
    logic [15:0] left;
    logic        ret;
    logic        done;
    logic [1:0]  sync;   // sync[1] is the synchronized ack
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t c, logic slp, logic wk, logic rm, logic bsy,
                                logic ack, logic clr);
    mdl_t n;
    logic ack_s;
    n      = c;
    ack_s  = c.sync[1];
    n.sync = {c.sync[0], ack};
    n.done = 1'b0;
    case (c.ph)
      M_ON:    if (slp && !wk) begin n.ph = M_DRAIN; n.ret = rm; end
      M_DRAIN: if (!bsy) begin n.ph = M_ISO; n.left = 16'(ISO_DLY); end
      M_ISO:   if (c.left == 16'd1) begin n.ph = M_RST; n.left = 16'(RST_DLY); end
               else n.left = c.left - 16'd1;
      M_RST:   if (c.left == 16'd1) begin n.ph = M_OFF_REQ; n.left = 16'(ACK_TIMEOUT); end
               else n.left = c.left - 16'd1;
      M_OFF_REQ: begin
        if (ack_s) begin n.ph = M_OFF; n.done = 1'b1; end
        else if (c.left == 16'd1) n.ph = M_ERR;
        else n.left = c.left - 16'd1;
      end
      M_OFF:   if (wk && !slp) begin n.ph = M_ON_REQ; n.left = 16'(ACK_TIMEOUT); end
      M_ON_REQ: begin
        if (!ack_s) begin n.ph = M_SETTLE; n.left = 16'(RST_DLY); end
        else if (c.left == 16'd1) n.ph = M_ERR;
        else n.left = c.left - 16'd1;
      end
      M_SETTLE: if (c.left == 16'd1) begin n.ph = M_UNISO; n.left = 16'(ISO_DLY); end
                else n.left = c.left - 16'd1;
      M_UNISO: if (c.left == 16'd1) begin n.ph = M_ON; n.done = 1'b1; end
               else n.left = c.left - 16'd1;
      M_ERR:   if (clr) n.ph = M_OFF;
      default: n.ph = M_ERR;
    endcase
    return n;
  endfunction

  // Pin values each phase must show: {switch, iso, rst_n, ret, busy}.
  function automatic logic [4:0] pins(logic [3:0] ph, logic ret);
    logic sw, iso, rn, r, b;
    sw  = (ph == M_OFF_REQ) || (ph == M_OFF) || (ph == M_ERR);
    iso = !((ph == M_ON) || (ph == M_DRAIN) || (ph == M_UNISO));
    rn  = (ph == M_ON) || (ph == M_DRAIN) || (ph == M_ISO);
    r   = ret && iso;
    b   = !((ph == M_ON) || (ph == M_OFF) || (ph == M_ERR));
    return {sw, iso, rn, r, b};
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m <= '0;
    else       m <= step(m, sleep_req_i, wake_req_i, ret_mode_i, cgra_busy_i,
                         pwr_ack_i, err_clr_i);
  end

  logic [10:0] got_v, exp_v;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      got_v = {state_o, pwr_switch_o, iso_o, dom_rst_no, ret_o, busy_o, done_o, err_o};
      exp_v = {m.ph, pins(m.ph, m.ret), m.done, (m.ph == M_ERR)};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++;
        $display("FAIL model t=%0t {state,sw,iso,rst_n,ret,busy,done,err} got %b expected %b",
                 $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, input string name);
    int n = 0;
    while (state_o !== s && n < max) begin
      cyc();
      n++;
    end
    chk(name, int'(state_o), int'(s));
  endtask

  task automatic pulse(input bit slp, input bit wk);
    sleep_req_i = slp;
    wake_req_i  = wk;
    cyc();
    sleep_req_i = 1'b0;
    wake_req_i  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) cyc();
    chk("rst_state", int'(state_o), 0);
    chk("rst_dom_rst_no", int'(dom_rst_no), 1);
    chk("rst_switch", int'(pwr_switch_o), 0);
    chk("rst_iso", int'(iso_o), 0);
    rst_i = 1'b0;
    repeat (2) cyc();

    // Plain sleep: cycle indices relative to the request cycle.
    pulse(1, 0);                                   // now cycle 1
    chk("t1_iso_c1", int'(iso_o), 0);
    cyc(); chk("t1_iso_c2", int'(iso_o), 1);
    repeat (3) cyc(); chk("t1_rstn_c5", int'(dom_rst_no), 1);
    cyc(); chk("t1_rstn_c6", int'(dom_rst_no), 0);
    repeat (3) cyc(); chk("t1_sw_c9", int'(pwr_switch_o), 0);
    cyc(); chk("t1_sw_c10", int'(pwr_switch_o), 1);
    repeat (3) cyc(); chk("t1_state_c13", int'(state_o), 5);
    chk("t1_done_c13", int'(done_o), 1);
    cyc(); chk("t1_done_c14", int'(done_o), 0);
    repeat (3) cyc();

    // Wake from OFF.
    pulse(0, 1);                                   // cycle 1
    chk("t2_state_c1", int'(state_o), 6);
    chk("t2_sw_c1", int'(pwr_switch_o), 0);
    repeat (3) cyc(); chk("t2_settle_c4", int'(state_o), 7);
    repeat (4) cyc(); chk("t2_uniso_c8", int'(state_o), 8);
    chk("t2_iso_c8", int'(iso_o), 0);
    chk("t2_rstn_c8", int'(dom_rst_no), 0);
    repeat (4) cyc(); chk("t2_state_c12", int'(state_o), 0);
    chk("t2_done_c12", int'(done_o), 1);
    chk("t2_rstn_c12", int'(dom_rst_no), 1);
    repeat (2) cyc();

    // Busy CGRA holds DRAIN.
    cgra_busy_i = 1'b1;
    pulse(1, 0);
    for (int i = 0; i < 20; i++) begin
      chk("t3_drain_state", int'(state_o), 1);
      chk("t3_drain_iso", int'(iso_o), 0);
      cyc();
    end
    cgra_busy_i = 1'b0;
    wait_state(M_OFF, 40, "t3_reach_off");
    pulse(0, 1);
    wait_state(M_ON, 40, "t3_reach_on");
    repeat (2) cyc();

    // Retention through the sequence.
    ret_mode_i = 1'b1;
    pulse(1, 0);
    ret_mode_i = 1'b0;
    chk("t5_ret_c1", int'(ret_o), 0);
    cyc(); chk("t5_ret_c2", int'(ret_o), 1);
    wait_state(M_OFF, 40, "t5_reach_off");
    chk("t5_ret_off", int'(ret_o), 1);
    pulse(0, 1);
    repeat (3) cyc(); chk("t5_ret_settle", int'(ret_o), 1);
    repeat (4) cyc(); chk("t5_ret_uniso", int'(ret_o), 0);
    wait_state(M_ON, 20, "t5_reach_on");
    repeat (2) cyc();

    // Missing acknowledge -> timeout -> ERR -> clear.
    ack_stuck0 = 1'b1;
    pulse(1, 0);
    wait_state(M_OFF_REQ, 40, "t4_reach_off_req");
    n = 0;
    while (state_o == M_OFF_REQ && n < 400) begin
      cyc();
      n++;
    end
    chk("t4_timeout_cycles", n, ACK_TIMEOUT);
    chk("t4_state_err", int'(state_o), 9);
    chk("t4_err", int'(err_o), 1);
    chk("t4_err_sw", int'(pwr_switch_o), 1);
    repeat (3) cyc();
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    chk("t4_clr_state", int'(state_o), 5);
    chk("t4_clr_err", int'(err_o), 0);
    chk("t4_clr_done", int'(done_o), 0);
    ack_stuck0 = 1'b0;
    repeat (4) cyc();
    pulse(0, 1);
    wait_state(M_ON, 40, "t4_reach_on");
    repeat (2) cyc();

    // Conflicting and misplaced requests.
    pulse(1, 1);
    chk("t6_both_c1", int'(state_o), 0);
    cyc(); chk("t6_both_c2", int'(state_o), 0);
    pulse(1, 0);
    wait_state(M_OFF, 40, "t6_reach_off");
    ack_stuck1 = 1'b1;
    pulse(0, 1);
    chk("t6_on_req", int'(state_o), 6);
    pulse(1, 0);
    chk("t6_sleep_ignored", int'(state_o), 6);
    cyc(); chk("t6_sleep_ignored2", int'(state_o), 6);
    ack_stuck1 = 1'b0;
    wait_state(M_ON, 40, "t6_reach_on");

    // Asynchronous reset while the domain is held in reset.
    pulse(1, 0);
    wait_state(M_RST, 20, "t6_reach_rst");
    #2 rst_i = 1'b1;
    #1;
    chk("t6_arst_state", int'(state_o), 0);
    chk("t6_arst_rstn", int'(dom_rst_no), 1);
    chk("t6_arst_iso", int'(iso_o), 0);
    chk("t6_arst_sw", int'(pwr_switch_o), 0);
    chk("t6_arst_ret", int'(ret_o), 0);
    cyc();
    rst_i = 1'b0;
    repeat (3) cyc();

    // Randomized traffic, switch behaviour changes in long epochs.
    for (int i = 0; i < 4000; i++) begin
      if (i % 600 == 0) begin
        ack_stuck0 = 1'b0; ack_stuck1 = 1'b0; ack_slow = 1'b0;
        case ($urandom_range(0, 3))
          0: ;
          1: ack_slow = 1'b1;
          2: ack_stuck0 = 1'b1;
          default: ack_stuck1 = 1'b1;
        endcase
      end
      sleep_req_i = ($urandom_range(0, 7) == 0);
      wake_req_i  = ($urandom_range(0, 7) == 0);
      ret_mode_i  = $urandom_range(0, 1) == 1;
      err_clr_i   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) cgra_busy_i = ~cgra_busy_i;
      cyc();
    end
    sleep_req_i = 1'b0;
    wake_req_i  = 1'b0;
    err_clr_i   = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
